// File: rtl/axis_width_split.sv
// AXI-Stream width splitter: breaks each wide slave word into RATIO narrow master beats with
// selectable slice order, strobe-driven null-slice skipping and an optional input skid register.
module axis_width_split #(
   parameter int unsigned C_M_AXIS_TDATA_WIDTH = 16,
   parameter int unsigned RATIO                = 2,
   parameter bit          MSH_FIRST            = 1'b0,
   parameter bit          ENABLE_TSTRB         = 1'b1,
   parameter bit          ENABLE_TLAST         = 1'b1,
   parameter bit          SKIP_NULL            = 1'b0,
   parameter              BUFFER_MODE          = "NONE"
) (
   input  logic                                    axis_aclk,
   input  logic                                    axis_areset,
   input  logic                                    s_axis_tvalid,
   output logic                                    s_axis_tready,
   input  logic [C_M_AXIS_TDATA_WIDTH*RATIO-1:0]   s_axis_tdata,
   input  logic [C_M_AXIS_TDATA_WIDTH*RATIO/8-1:0] s_axis_tstrb,
   input  logic                                    s_axis_tlast,
   output logic                                    m_axis_tvalid,
   input  logic                                    m_axis_tready,
   output logic [C_M_AXIS_TDATA_WIDTH-1:0]         m_axis_tdata,
   output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]       m_axis_tstrb,
   output logic                                    m_axis_tlast
);

   localparam int W    = int'(C_M_AXIS_TDATA_WIDTH);
   localparam int R    = int'(RATIO);
   localparam int SW   = W * R;
   localparam int MB   = W / 8;
   localparam int SB   = SW / 8;
   localparam int PW   = $clog2(R);
   localparam bit FULL = (BUFFER_MODE == "FULL");
   localparam bit SKIP = SKIP_NULL && ENABLE_TSTRB;

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   // Positions count in emission order; slice_idx maps them onto word slices.
   function automatic int slice_idx(input int p);
      return MSH_FIRST ? (R - 1 - p) : p;
   endfunction

   function automatic logic slice_live(input logic [SB-1:0] strb, input int p);
      return !SKIP || (strb[slice_idx(p)*MB +: MB] != '0);
   endfunction

   // Next emitted position strictly after p, or R when p is the final one.
   function automatic int next_pos(input logic [SB-1:0] strb, input int p);
      int n;
      n = R;
      for (int k = R - 1; k >= 0; k--) begin
         if (k > p && slice_live(strb, k)) n = k;
      end
      return n;
   endfunction

   function automatic logic [W-1:0] get_data(input logic [SW-1:0] d, input int p);
      return d[slice_idx(p)*W +: W];
   endfunction

   function automatic logic [MB-1:0] get_strb(input logic [SB-1:0] s, input int p);
      return s[slice_idx(p)*MB +: MB];
   endfunction

   state_e          r_state;
   logic [PW-1:0]   r_pos;
   logic [SW-1:0]   r_data;
   logic [SB-1:0]   r_strb;
   logic            r_last;
   logic            r_m_tvalid;
   logic [W-1:0]    r_m_tdata;
   logic [MB-1:0]   r_m_tstrb;
   logic            r_m_tlast;
   logic            r_skid_full;
   logic [SW-1:0]   r_skid_data;
   logic [SB-1:0]   r_skid_strb;
   logic            r_skid_last;

   logic [SB-1:0]   w_in_strb;
   logic            w_in_last;
   logic            w_final;
   int              w_nxt_pos;
   logic            w_nxt_last;
   logic            w_m_hs;
   logic            w_last_hs;
   logic            w_s_ready;
   logic            w_s_hs;
   logic            w_load_skid;
   logic            w_load_in;
   logic            w_to_skid;
   logic [SW-1:0]   w_ld_data;
   logic [SB-1:0]   w_ld_strb;
   logic            w_ld_last;
   int              w_ld_pos;
   logic            w_ld_final;

   // With strobes disabled every slice is treated as fully valid.
   assign w_in_strb = ENABLE_TSTRB ? s_axis_tstrb : '1;
   assign w_in_last = ENABLE_TLAST && s_axis_tlast;

   always_comb begin
      w_final     = (next_pos(r_strb, int'(r_pos)) == R);
      w_nxt_pos   = w_final ? int'(r_pos) : next_pos(r_strb, int'(r_pos));
      w_nxt_last  = r_last && (next_pos(r_strb, w_nxt_pos) == R);
      w_m_hs      = r_m_tvalid && m_axis_tready;
      w_last_hs   = w_m_hs && w_final;
      w_s_ready   = FULL ? !r_skid_full
                         : ((r_state == StIdle) || (w_final && m_axis_tready));
      w_s_hs      = s_axis_tvalid && w_s_ready && !axis_areset;
      w_load_skid = FULL && r_skid_full && w_last_hs;
      w_load_in   = w_s_hs && ((r_state == StIdle) || (w_last_hs && !r_skid_full));
      w_to_skid   = FULL && w_s_hs && !w_load_in;
      w_ld_data   = w_load_skid ? r_skid_data : s_axis_tdata;
      w_ld_strb   = w_load_skid ? r_skid_strb : w_in_strb;
      w_ld_last   = w_load_skid ? r_skid_last : w_in_last;
      // An all-null word still emits its final slice so tlast is never lost.
      w_ld_pos    = next_pos(w_ld_strb, -1);
      if (w_ld_pos == R) w_ld_pos = R - 1;
      w_ld_final  = (next_pos(w_ld_strb, w_ld_pos) == R);
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         r_state     <= StIdle;
         r_pos       <= '0;
         r_data      <= '0;
         r_strb      <= '0;
         r_last      <= 1'b0;
         r_m_tvalid  <= 1'b0;
         r_m_tdata   <= '0;
         r_m_tstrb   <= '0;
         r_m_tlast   <= 1'b0;
         r_skid_full <= 1'b0;
         r_skid_data <= '0;
         r_skid_strb <= '0;
         r_skid_last <= 1'b0;
      end else begin
         if (w_to_skid) begin
            r_skid_full <= 1'b1;
            r_skid_data <= s_axis_tdata;
            r_skid_strb <= w_in_strb;
            r_skid_last <= w_in_last;
         end else if (w_load_skid) begin
            r_skid_full <= 1'b0;
         end

         if (w_load_skid || w_load_in) begin
            r_state    <= StSend;
            r_data     <= w_ld_data;
            r_strb     <= w_ld_strb;
            r_last     <= w_ld_last;
            r_pos      <= PW'(w_ld_pos);
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= get_data(w_ld_data, w_ld_pos);
            r_m_tstrb  <= get_strb(w_ld_strb, w_ld_pos);
            r_m_tlast  <= w_ld_last && w_ld_final;
         end else if (w_m_hs) begin
            if (w_final) begin
               r_state    <= StIdle;
               r_m_tvalid <= 1'b0;
            end else begin
               r_pos     <= PW'(w_nxt_pos);
               r_m_tdata <= get_data(r_data, w_nxt_pos);
               r_m_tstrb <= get_strb(r_strb, w_nxt_pos);
               r_m_tlast <= w_nxt_last;
            end
         end
      end
   end

   assign s_axis_tready = w_s_ready && !axis_areset;
   assign m_axis_tvalid = r_m_tvalid;
   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tstrb  = r_m_tstrb;
   assign m_axis_tlast  = r_m_tlast;

endmodule

// File: tb/tb_axis_width_split.sv
// Directed bench for axis_width_split: five differently configured instances, one task per
// scenario, each comparing monitored master beats against hand-computed values.
module tb_axis_width_split;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   cyc = 0;
   int   total;
   int   bad;

   // Lanes: 0 R4/MSH1/NONE, 1 R4/MSH1/FULL, 2 R4/SKIP/FULL, 3 R4/no strb+last, 4 R2 W16.
   logic [4:0]       s_v, s_r, s_l, m_v, m_r, m_l;
   logic [4:0][31:0] s_d;
   logic [4:0][3:0]  s_s;
   logic [3:0][7:0]  m_d;
   logic [3:0]       m_s;
   logic [15:0]      a_d;
   logic [1:0]       a_s;

   typedef struct {
      int          lane;
      logic [15:0] d;
      logic [1:0]  s;
      logic        l;
      int          c;
   } beat_t;
   beat_t q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int n = 0; n < 5; n++) begin
         if (m_v[n] && m_r[n])
            q.push_back('{n, (n == 4) ? a_d : {8'h00, m_d[n]},
                          (n == 4) ? a_s : {1'b0, m_s[n]}, m_l[n], cyc});
      end
   end

   axis_width_split #(.C_M_AXIS_TDATA_WIDTH(8), .RATIO(4), .MSH_FIRST(1'b1),
                      .BUFFER_MODE("NONE")) u_b (
      .axis_aclk(clk), .axis_areset(rst), .s_axis_tvalid(s_v[0]), .s_axis_tready(s_r[0]),
      .s_axis_tdata(s_d[0]), .s_axis_tstrb(s_s[0]), .s_axis_tlast(s_l[0]),
      .m_axis_tvalid(m_v[0]), .m_axis_tready(m_r[0]), .m_axis_tdata(m_d[0]),
      .m_axis_tstrb(m_s[0]), .m_axis_tlast(m_l[0]));

   axis_width_split #(.C_M_AXIS_TDATA_WIDTH(8), .RATIO(4), .MSH_FIRST(1'b1),
                      .BUFFER_MODE("FULL")) u_c (
      .axis_aclk(clk), .axis_areset(rst), .s_axis_tvalid(s_v[1]), .s_axis_tready(s_r[1]),
      .s_axis_tdata(s_d[1]), .s_axis_tstrb(s_s[1]), .s_axis_tlast(s_l[1]),
      .m_axis_tvalid(m_v[1]), .m_axis_tready(m_r[1]), .m_axis_tdata(m_d[1]),
      .m_axis_tstrb(m_s[1]), .m_axis_tlast(m_l[1]));

   axis_width_split #(.C_M_AXIS_TDATA_WIDTH(8), .RATIO(4), .MSH_FIRST(1'b0),
                      .SKIP_NULL(1'b1), .BUFFER_MODE("FULL")) u_d (
      .axis_aclk(clk), .axis_areset(rst), .s_axis_tvalid(s_v[2]), .s_axis_tready(s_r[2]),
      .s_axis_tdata(s_d[2]), .s_axis_tstrb(s_s[2]), .s_axis_tlast(s_l[2]),
      .m_axis_tvalid(m_v[2]), .m_axis_tready(m_r[2]), .m_axis_tdata(m_d[2]),
      .m_axis_tstrb(m_s[2]), .m_axis_tlast(m_l[2]));

   axis_width_split #(.C_M_AXIS_TDATA_WIDTH(8), .RATIO(4), .MSH_FIRST(1'b0),
                      .ENABLE_TSTRB(1'b0), .ENABLE_TLAST(1'b0), .SKIP_NULL(1'b1),
                      .BUFFER_MODE("NONE")) u_e (
      .axis_aclk(clk), .axis_areset(rst), .s_axis_tvalid(s_v[3]), .s_axis_tready(s_r[3]),
      .s_axis_tdata(s_d[3]), .s_axis_tstrb(s_s[3]), .s_axis_tlast(s_l[3]),
      .m_axis_tvalid(m_v[3]), .m_axis_tready(m_r[3]), .m_axis_tdata(m_d[3]),
      .m_axis_tstrb(m_s[3]), .m_axis_tlast(m_l[3]));

   axis_width_split #(.C_M_AXIS_TDATA_WIDTH(16), .RATIO(2), .MSH_FIRST(1'b0),
                      .BUFFER_MODE("NONE")) u_a (
      .axis_aclk(clk), .axis_areset(rst), .s_axis_tvalid(s_v[4]), .s_axis_tready(s_r[4]),
      .s_axis_tdata(s_d[4]), .s_axis_tstrb(s_s[4]), .s_axis_tlast(s_l[4]),
      .m_axis_tvalid(m_v[4]), .m_axis_tready(m_r[4]), .m_axis_tdata(a_d),
      .m_axis_tstrb(a_s), .m_axis_tlast(m_l[4]));

   // Called one time unit after a rising edge; returns likewise after the handshake edge.
   task automatic send_word(input int lane, input logic [31:0] d, input logic [3:0] s,
                            input logic l, output int hc, output bit to);
      s_v[lane] = 1'b1;
      s_d[lane] = d;
      s_s[lane] = s;
      s_l[lane] = l;
      to = 1'b1;
      hc = -1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (s_r[lane]) begin
            hc = cyc;
            to = 1'b0;
         end
         @(posedge clk);
         #1;
         if (!to) break;
      end
      s_v[lane] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (m_v !== 5'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=00000", m_v); end
      total++;
      if (m_l !== 5'b0) begin bad++; $display("FAIL reset_tlast got=%b want=00000", m_l); end
      total++;
      if ({m_d, a_d} !== 48'h0) begin
         bad++; $display("FAIL reset_tdata got=%h/%h want=0", m_d, a_d);
      end
      total++;
      if ({m_s, a_s} !== 6'h0) begin
         bad++; $display("FAIL reset_tstrb got=%b/%b want=0", m_s, a_s);
      end
      total++;
      if (s_r !== 5'b0) begin bad++; $display("FAIL reset_sready got=%b want=00000", s_r); end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (s_r !== 5'b11111) begin
         bad++; $display("FAIL release_sready got=%b want=11111", s_r);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_ratio2();
      int          hc;
      bit          to;
      logic [15:0] ed [2] = '{16'h5678, 16'h1234};
      q.delete();
      m_r[4] = 1'b1;
      send_word(4, 32'h12345678, 4'hF, 1'b1, hc, to);
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (to || q.size() != 2) begin
         bad++; $display("FAIL r2_count got=%0d want=2 timeout=%0d", q.size(), to);
      end else begin
         for (int i = 0; i < 2; i++) begin
            total++;
            if ({q[i].d, q[i].s, q[i].l} !== {ed[i], 2'b11, (i == 1)}) begin
               bad++;
               $display("FAIL r2_beat%0d got=%h/%b/%b want=%h/11/%b", i, q[i].d, q[i].s,
                        q[i].l, ed[i], (i == 1));
            end
         end
         total++;
         if (q[0].c !== hc + 1 || q[1].c !== hc + 2) begin
            bad++;
            $display("FAIL r2_latency got=%0d,%0d want=%0d,%0d", q[0].c, q[1].c, hc + 1,
                     hc + 2);
         end
      end
   endtask

   task automatic test_back_to_back(input int lane);
      int         hc0, hc1;
      bit         to0, to1;
      logic [7:0] ed [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
      q.delete();
      m_r[lane] = 1'b1;
      send_word(lane, 32'hAABBCCDD, 4'hF, 1'b0, hc0, to0);
      send_word(lane, 32'h11223344, 4'hF, 1'b1, hc1, to1);
      repeat (8) @(posedge clk);
      #1;
      total++;
      if (to0 || to1 || q.size() != 8) begin
         bad++; $display("FAIL b2b%0d_count got=%0d want=8", lane, q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if ({q[i].d, q[i].s, q[i].l} !== {8'h00, ed[i], 2'b01, (i == 7)} ||
                q[i].c !== hc0 + 1 + i) begin
               bad++;
               $display("FAIL b2b%0d_beat%0d got=%h/%b/%b@%0d want=%h/01/%b@%0d", lane, i,
                        q[i].d, q[i].s, q[i].l, q[i].c, ed[i], (i == 7), hc0 + 1 + i);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int         hc [3];
      bit         to [3];
      logic       sr [24];
      logic [9:0] prev, cur;
      logic       stalled;
      logic [7:0] ed [12] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44,
                              8'h55, 8'h66, 8'h77, 8'h88};
      q.delete();
      stalled = 1'b0;
      prev = '0;
      fork
         begin
            send_word(1, 32'hAABBCCDD, 4'hF, 1'b0, hc[0], to[0]);
            send_word(1, 32'h11223344, 4'hF, 1'b1, hc[1], to[1]);
            send_word(1, 32'h55667788, 4'hF, 1'b1, hc[2], to[2]);
         end
         begin
            for (int k = 0; k < 24; k++) begin
               m_r[1] = (k == 2 || k == 3) ? 1'b0 : 1'b1;
               @(negedge clk);
               sr[k] = s_r[1];
               cur = {m_d[1], m_s[1], m_l[1]};
               if (stalled) begin
                  total++;
                  if (cur !== prev) begin
                     bad++; $display("FAIL stall_hold k=%0d got=%h want=%h", k, cur, prev);
                  end
               end
               stalled = m_v[1] && !m_r[1];
               prev = cur;
               @(posedge clk);
               #1;
            end
         end
      join
      total++;
      if ({sr[1], sr[2], sr[6], sr[7]} !== 4'b1001) begin
         bad++;
         $display("FAIL skid_sready got=%b%b%b%b want=1001", sr[1], sr[2], sr[6], sr[7]);
      end
      total++;
      if (to[0] || to[1] || to[2] || q.size() != 12) begin
         bad++; $display("FAIL bp_count got=%0d want=12", q.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            total++;
            if ({q[i].d, q[i].l} !== {8'h00, ed[i], (i == 7 || i == 11)}) begin
               bad++;
               $display("FAIL bp_beat%0d got=%h/%b want=%h/%b", i, q[i].d, q[i].l, ed[i],
                        (i == 7 || i == 11));
            end
         end
      end
   endtask

   task automatic test_skip_null();
      int         hc [3];
      bit         to [3];
      logic [7:0] ed [4] = '{8'hBB, 8'hAA, 8'hCC, 8'hAA};
      logic       es [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic       el [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      q.delete();
      m_r[2] = 1'b1;
      send_word(2, 32'hAABBCCDD, 4'b0100, 1'b1, hc[0], to[0]);
      send_word(2, 32'hAABBCCDD, 4'b0000, 1'b1, hc[1], to[1]);
      send_word(2, 32'hAABBCCDD, 4'b1010, 1'b1, hc[2], to[2]);
      repeat (6) @(posedge clk);
      #1;
      total++;
      if (to[0] || to[1] || to[2] || q.size() != 4) begin
         bad++; $display("FAIL skip_count got=%0d want=4", q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if ({q[i].d, q[i].s, q[i].l} !== {8'h00, ed[i], 1'b0, es[i], el[i]} ||
                q[i].c !== hc[0] + 1 + i) begin
               bad++;
               $display("FAIL skip_beat%0d got=%h/%b/%b@%0d want=%h/%b/%b@%0d", i, q[i].d,
                        q[i].s, q[i].l, q[i].c, ed[i], es[i], el[i], hc[0] + 1 + i);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int         hc;
      bit         to0, to1;
      logic [7:0] ed [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      q.delete();
      m_r[0] = 1'b1;
      send_word(0, 32'hAABBCCDD, 4'hF, 1'b1, hc, to0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      m_r[0] = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (m_v[0] !== 1'b0) begin bad++; $display("FAIL midrst_tvalid got=%b want=0", m_v[0]); end
      rst = 1'b0;
      q.delete();
      m_r[0] = 1'b1;
      @(negedge clk);
      total++;
      if (s_r[0] !== 1'b1) begin bad++; $display("FAIL midrst_sready got=%b want=1", s_r[0]); end
      @(posedge clk);
      #1;
      send_word(0, 32'h11223344, 4'hF, 1'b1, hc, to1);
      repeat (6) @(posedge clk);
      #1;
      total++;
      if (to0 || to1 || q.size() != 4) begin
         bad++; $display("FAIL midrst_count got=%0d want=4", q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if ({q[i].d, q[i].l} !== {8'h00, ed[i], (i == 3)}) begin
               bad++;
               $display("FAIL midrst_beat%0d got=%h/%b want=%h/%b", i, q[i].d, q[i].l, ed[i],
                        (i == 3));
            end
         end
      end
   endtask

   task automatic test_no_strb_last();
      int         hc;
      bit         to0, to1;
      logic [7:0] ed [8] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h3C, 8'h2D, 8'h1E, 8'h0F};
      q.delete();
      m_r[3] = 1'b1;
      send_word(3, 32'hDEADBEEF, 4'($urandom), 1'($urandom), hc, to0);
      send_word(3, 32'h0F1E2D3C, 4'b0000, 1'b1, hc, to1);
      repeat (8) @(posedge clk);
      #1;
      total++;
      if (to0 || to1 || q.size() != 8) begin
         bad++; $display("FAIL nostrb_count got=%0d want=8", q.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if ({q[i].d, q[i].s, q[i].l} !== {8'h00, ed[i], 2'b01, 1'b0}) begin
               bad++;
               $display("FAIL nostrb_beat%0d got=%h/%b/%b want=%h/01/0", i, q[i].d, q[i].s,
                        q[i].l, ed[i]);
            end
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      s_v   = '0;
      s_l   = '0;
      s_d   = '0;
      s_s   = '0;
      m_r   = '0;
      test_reset();
      test_ratio2();
      test_back_to_back(0);
      test_back_to_back(1);
      test_backpressure();
      test_skip_null();
      test_reset_mid();
      test_no_strb_last();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
